// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: reset payloads, stage payload structs and small helpers.
// Stage registers size themselves with $bits() of these structs.
package pipe_pkg;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] PC_RST = 32'h00000000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } id_ex_t;

  // Number of live entries given the main and skid valid bits.
  function automatic logic [1:0] occupancy(input logic main_v, input logic skid_v);
    return {main_v & skid_v, main_v ^ skid_v};
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for one elastic stage boundary; names follow the stage's point of view.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             i_ready;
  logic [1:0]       o_count;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_count
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_count
  );
endinterface

// File: rtl/d_ff.sv
// Enabled register with synchronous active-high reset to a parameterised value.
module d_ff #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: main entry plus optional skid entry so upstream ready is registered.
// Flush and reset both clear every entry and force o_data back to RST_VAL.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(PC_RST),
  parameter bit               SKID    = 1'b1
) (
  input logic            i_clk,
  input logic            i_rst,
  input logic            i_flush,
  pipe_skid_reg_if.slave bus
);

  logic             w_clr;
  logic             w_valid;
  logic             w_skid_valid;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;
  logic             w_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_valid_next;
  logic             w_main_en;
  logic [WIDTH-1:0] w_main_next;
  logic             w_skid_valid_next;
  logic             w_skid_en;

  assign w_clr      = i_rst | i_flush;
  assign w_in_fire  = bus.i_valid & w_ready;
  assign w_out_fire = w_valid & bus.i_ready;

  generate
    if (SKID) begin : g_skid
      assign w_ready = ~w_skid_valid;
    end else begin : g_single
      assign w_ready = ~w_valid | bus.i_ready;
    end
  endgenerate

  always_comb begin
    w_valid_next      = w_valid;
    w_main_en         = 1'b0;
    w_main_next       = w_main_q;
    w_skid_valid_next = w_skid_valid;
    w_skid_en         = 1'b0;
    if (w_skid_valid) begin
      // Ready is low here, so the only event is the main entry draining.
      if (w_out_fire) begin
        w_main_en         = 1'b1;
        w_main_next       = w_skid_q;
        w_skid_valid_next = 1'b0;
      end
    end else if (w_valid) begin
      if (w_in_fire && w_out_fire) begin
        w_main_en   = 1'b1;
        w_main_next = bus.i_data;
      end else if (w_in_fire) begin
        w_skid_en         = SKID;
        w_skid_valid_next = SKID;
      end else if (w_out_fire) begin
        w_valid_next = 1'b0;
      end
    end else if (w_in_fire) begin
      w_main_en    = 1'b1;
      w_main_next  = bus.i_data;
      w_valid_next = 1'b1;
    end
  end

  d_ff #(.WIDTH(1), .RST_VAL(1'b0)) u_valid (
    .i_clk(i_clk), .i_rst(w_clr), .i_en(1'b1), .i_d(w_valid_next), .o_q(w_valid)
  );

  d_ff #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
    .i_clk(i_clk), .i_rst(w_clr), .i_en(w_main_en), .i_d(w_main_next), .o_q(w_main_q)
  );

  d_ff #(.WIDTH(1), .RST_VAL(1'b0)) u_skid_valid (
    .i_clk(i_clk), .i_rst(w_clr), .i_en(1'b1), .i_d(w_skid_valid_next), .o_q(w_skid_valid)
  );

  d_ff #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
    .i_clk(i_clk), .i_rst(w_clr), .i_en(w_skid_en), .i_d(bus.i_data), .o_q(w_skid_q)
  );

  assign bus.o_ready = w_ready;
  assign bus.o_valid = w_valid;
  assign bus.o_data  = w_main_q;
  assign bus.o_count = occupancy(w_valid, w_skid_valid);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed table plus random scoreboard for pipe_skid_reg, SKID=1 (dut1) and SKID=0 (dut0).
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        drv_f [2];
  logic        drv_v [2];
  logic [31:0] drv_d [2];
  logic        drv_r [2];
  logic        mon_v [2];
  logic [31:0] mon_d [2];
  logic [1:0]  mon_c [2];
  logic        mon_r [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.WIDTH(32)) bus0 ();
  pipe_skid_reg_if #(.WIDTH(32)) bus1 ();

  assign bus0.i_valid = drv_v[0];
  assign bus0.i_data  = drv_d[0];
  assign bus0.i_ready = drv_r[0];
  assign bus1.i_valid = drv_v[1];
  assign bus1.i_data  = drv_d[1];
  assign bus1.i_ready = drv_r[1];
  assign mon_v[0] = bus0.o_valid;
  assign mon_d[0] = bus0.o_data;
  assign mon_c[0] = bus0.o_count;
  assign mon_r[0] = bus0.o_ready;
  assign mon_v[1] = bus1.o_valid;
  assign mon_d[1] = bus1.o_data;
  assign mon_c[1] = bus1.o_count;
  assign mon_r[1] = bus1.o_ready;

  pipe_skid_reg #(.WIDTH(32), .RST_VAL(NOP), .SKID(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(drv_f[0]), .bus(bus0)
  );
  pipe_skid_reg #(.WIDTH(32), .RST_VAL(NOP), .SKID(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_flush(drv_f[1]), .bus(bus1)
  );

  typedef struct {
    logic        f;
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  ec;
    logic        er;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input int k, input logic ev, input logic [31:0] ed,
                     input logic [1:0] ec, input logic er);
    n_vec++;
    if (mon_v[k] !== ev || mon_d[k] !== ed || mon_c[k] !== ec || mon_r[k] !== er) begin
      n_bad++;
      $display("FAIL %s dut%0d: got v=%0b d=%h cnt=%0d rdy=%0b, want v=%0b d=%h cnt=%0d rdy=%0b",
               nm, k, mon_v[k], mon_d[k], mon_c[k], mon_r[k], ev, ed, ec, er);
    end else begin
      $display("ok   %s dut%0d: v=%0b d=%h cnt=%0d rdy=%0b", nm, k, mon_v[k], mon_d[k],
               mon_c[k], mon_r[k]);
    end
  endtask

  int          wr [2];
  int          rd [2];
  logic [31:0] sb [2][4];
  logic        hold [2];
  logic        stl [2];
  logic [31:0] stl_d [2];
  logic [31:0] seq [2];
  logic        in_f;
  logic        out_f;

  initial begin
    //         f     v     d          r     ev    ed         ec    er
    tbl[0]  = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 2'd1, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 32'h104, 1'b1, 1'b1, 32'h104, 2'd1, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 32'h108, 2'd1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 32'h108, 1'b1, 1'b0, 32'h108, 2'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 32'hA0,  1'b0, 1'b1, 32'hA0,  2'd1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'hB0,  1'b0, 1'b1, 32'hA0,  2'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'hC0,  1'b0, 1'b1, 32'hA0,  2'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'hC0,  1'b1, 1'b1, 32'hB0,  2'd1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 32'hC0,  1'b1, 1'b1, 32'hC0,  2'd1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 32'hC0,  1'b1, 1'b0, 32'hC0,  2'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'hD0,  1'b0, 1'b1, 32'hD0,  2'd1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 32'hE0,  1'b0, 1'b1, 32'hD0,  2'd2, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 32'hC5,  1'b0, 1'b0, NOP,     2'd0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'hC5,  1'b1, 1'b0, NOP,     2'd0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 32'hF0,  1'b1, 1'b1, 32'hF0,  2'd1, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 32'h77,  1'b1, 1'b0, NOP,     2'd0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 32'h20,  1'b0, 1'b1, 32'h20,  2'd1, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 32'h20,  1'b0, 1'b1, 32'h20,  2'd1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 32'h20,  1'b1, 1'b0, 32'h20,  2'd0, 1'b1};

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drv_f[k] = 1'b0; drv_v[k] = 1'b0; drv_d[k] = '0; drv_r[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, 1'b0, NOP, 2'd0, 1'b1);
    chk("reset", 1, 1'b0, NOP, 2'd0, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drv_f[1] = tbl[i].f; drv_v[1] = tbl[i].v; drv_d[1] = tbl[i].d; drv_r[1] = tbl[i].r;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), 1, tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].er);
    end
    drv_f[1] = 1'b0; drv_v[1] = 1'b0; drv_r[1] = 1'b0;

    // Single-entry build: ready follows i_ready combinationally.
    drv_v[0] = 1'b1; drv_d[0] = 32'h200; drv_r[0] = 1'b0;
    #1; chk("s0_empty_rdy", 0, 1'b0, NOP, 2'd0, 1'b1);
    @(posedge clk); #1; drv_v[0] = 1'b0;
    #1; chk("s0_load_stall", 0, 1'b1, 32'h200, 2'd1, 1'b0);
    @(posedge clk); #1; chk("s0_hold", 0, 1'b1, 32'h200, 2'd1, 1'b0);
    drv_v[0] = 1'b1; drv_d[0] = 32'h204; drv_r[0] = 1'b1;
    #1; chk("s0_comb_rdy", 0, 1'b1, 32'h200, 2'd1, 1'b1);
    @(posedge clk); #1; drv_v[0] = 1'b0;
    #1; chk("s0_replace", 0, 1'b1, 32'h204, 2'd1, 1'b1);
    @(posedge clk); #1; chk("s0_drain", 0, 1'b0, 32'h204, 2'd0, 1'b1);

    for (int k = 0; k < 2; k++) begin
      wr[k] = 0; rd[k] = 0; hold[k] = 1'b0; stl[k] = 1'b0; stl_d[k] = '0;
      seq[k] = 32'h1000_0000 + (k << 24);
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!hold[k]) begin
          drv_v[k] = ($urandom_range(0, 3) != 0);
          drv_d[k] = seq[k];
        end
        drv_r[k] = ($urandom_range(0, 2) != 0);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        if (stl[k]) begin
          n_vec++;
          if (mon_v[k] !== 1'b1 || mon_d[k] !== stl_d[k]) begin
            n_bad++;
            $display("FAIL stall_hold dut%0d cyc%0d: got v=%0b d=%h, want v=1 d=%h",
                     k, cyc, mon_v[k], mon_d[k], stl_d[k]);
          end
        end
        n_vec++;
        if (mon_c[k] !== 2'(wr[k] - rd[k])) begin
          n_bad++;
          $display("FAIL occupancy dut%0d cyc%0d: got %0d, want %0d", k, cyc, mon_c[k],
                   wr[k] - rd[k]);
        end
        in_f  = drv_v[k] & mon_r[k];
        out_f = mon_v[k] & drv_r[k];
        if (out_f) begin
          n_vec++;
          if (wr[k] == rd[k]) begin
            n_bad++;
            $display("FAIL unexpected_out dut%0d cyc%0d: got d=%h, want no payload", k, cyc,
                     mon_d[k]);
          end else begin
            if (mon_d[k] !== sb[k][rd[k] % 4]) begin
              n_bad++;
              $display("FAIL order dut%0d cyc%0d: got d=%h, want d=%h", k, cyc, mon_d[k],
                       sb[k][rd[k] % 4]);
            end
            rd[k]++;
          end
        end
        if (in_f) begin
          sb[k][wr[k] % 4] = drv_d[k];
          wr[k]++;
          seq[k]++;
        end
        hold[k]  = drv_v[k] & ~in_f;
        stl[k]   = mon_v[k] & ~drv_r[k];
        stl_d[k] = mon_d[k];
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
